// File: rtl/hack_rom_loader.sv
// Hack ROM loader: UART byte frames (sync, length, big-endian words) into ROM.
// Define HACK_ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module hack_rom_loader #(
  parameter int unsigned ADDR_W         = 15,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                rom_we_q, rom_we_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [15:0]         rom_wdata_q, rom_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [7:0]          csum_q, csum_d;
  logic                active;
  logic                last_word;
  logic [15:0]         len_full;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    to_d        = to_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    csum_d      = csum_q;
    len_full    = {len_q[15:8], rx_data};
    last_word   = (17'(addr_q) + 17'd1) == {1'b0, len_q};
    active      = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI,
                                  S_DATA_LO, S_END};
    if (rx_valid) begin
      to_d = '0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN_HI;
            csum_d  = '0;
          end
        end
        S_LEN_HI: begin
          len_d[15:8] = rx_data;
          csum_d      = csum_q ^ rx_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d  = len_full;
          addr_d = '0;
          csum_d = csum_q ^ rx_data;
          if ({1'b0, len_full} > MAX_LEN) state_d = S_ERROR;
          else if (len_full == '0)        state_d = S_END;
          else                            state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          rom_we_d    = 1'b1;
          rom_addr_d  = addr_q;
          rom_wdata_d = {hi_q, rx_data};
          csum_d      = csum_q ^ rx_data;
          if (last_word) begin
            state_d = S_END;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_DATA_HI;
          end
        end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        S_CHK: state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
`endif
        default: state_d = S_IDLE;
      endcase
    end else if (active) begin
      if (to_q == TO_LAST) begin
        state_d = S_ERROR;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
    // hold the CPU in reset through the cycle of the final write
    done_d      = (state_d == S_DONE) && !rom_we_d;
    cpu_reset_d = !done_d;
    error_d     = state_d == S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      to_q        <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      to_q        <= to_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      csum_q      <= csum_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: directed timing sequences, a vector table
// and random frames checked against a frame-level parser model.
module tb_hack_rom_loader;

  localparam int AW = 15;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int T = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rom_we;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  hack_rom_loader #(
    .ADDR_W(AW),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rom_we(rom_we),
    .rom_addr(rom_addr),
    .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int bad_we = 0;

  logic [AW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];

  // observed ROM writes, one entry per cycle rom_we is high
  always @(negedge clk) begin
    if (rom_we) begin
      wa_q.push_back(rom_addr);
      wd_q.push_back(rom_wdata);
      if (cpu_reset !== 1'b1 || done !== 1'b0) bad_we++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  logic [7:0]  fr[$];
  logic [15:0] exp_w[$];
  bit          exp_done;
  bit          exp_err;

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  function automatic logic [7:0] fr_xor();
    logic [7:0] x = 8'h00;
    bit seen = 1'b0;
    foreach (fr[i]) begin
      if (seen) x ^= fr[i];
      else if (fr[i] == SYNC) seen = 1'b1;
    end
    return x;
  endfunction

  // frame-level model: find sync, read length, emit words, judge checksum
  task automatic model();
    int i;
    int len;
    logic [7:0] x;
    exp_w = {};
    exp_done = 1'b0;
    exp_err = 1'b0;
    i = 0;
    while (i < fr.size() && fr[i] != SYNC) i++;
    len = int'({fr[i+1], fr[i+2]});
    if (len > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < len; k++)
      exp_w.push_back({fr[i+3+2*k], fr[i+4+2*k]});
    if (CHK_EN) begin
      x = 8'h00;
      for (int k = i + 1; k < i + 3 + 2 * len; k++) x ^= fr[k];
      exp_done = fr[i+3+2*len] == x;
      exp_err  = !exp_done;
    end else begin
      exp_done = 1'b1;
    end
  endtask

  task automatic run_frame(input string nm, input bit rnd);
    model();
    wa_q = {};
    wd_q = {};
    foreach (fr[i]) begin
      send(fr[i]);
      if (rnd) idle($urandom_range(0, 3));
    end
    idle(2);
    chk({nm, "_wcnt"}, wa_q.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < wa_q.size(); k++) begin
      chk({nm, "_waddr"}, 32'(wa_q[k]), k);
      chk({nm, "_wdata"}, 32'(wd_q[k]), 32'(exp_w[k]));
    end
    chk({nm, "_done"}, 32'(done), 32'(exp_done));
    chk({nm, "_err"}, 32'(error), 32'(exp_err));
    chk({nm, "_cpurst"}, 32'(cpu_reset), 32'(!exp_done));
  endtask

  typedef struct {
    logic [7:0] b [10];
    int         n;
    int         w;
    bit         d;
    bit         e;
    bit         c;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] g;
    int len;

    tbl[0] = '{b:'{8'hA5,8'h00,8'h01,8'h12,8'h34,0,0,0,0,0},
               n:5, w:1, d:1, e:0, c:1};
    tbl[1] = '{b:'{8'hA5,8'h00,8'h03,8'hA5,8'hA5,8'h00,8'h00,8'hFF,8'h01,0},
               n:9, w:3, d:1, e:0, c:1};
    tbl[2] = '{b:'{8'hA5,8'h80,8'h01,0,0,0,0,0,0,0},
               n:3, w:0, d:0, e:1, c:0};
    tbl[3] = '{b:'{8'h00,8'h12,8'hA5,8'h00,8'h00,0,0,0,0,0},
               n:5, w:0, d:1, e:0, c:1};
    tbl[4] = '{b:'{8'hA5,8'hFF,8'hFF,0,0,0,0,0,0,0},
               n:3, w:0, d:0, e:1, c:0};
    tbl[5] = '{b:'{8'hA5,8'h00,8'h02,8'h00,8'h01,8'h80,8'h00,0,0,0},
               n:7, w:2, d:1, e:0, c:1};

    @(posedge clk);
    #1;
    do_reset();
    chk("rst_we", 32'(rom_we), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_wdata", 32'(rom_wdata), 0);
    chk("rst_cpurst", 32'(cpu_reset), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(error), 0);

    // leading garbage then a two-word frame
    wa_q = {};
    wd_q = {};
    send(8'h00);
    chk("pre00_we", 32'(rom_we), 0);
    send(8'h12);
    chk("pre12_cpurst", 32'(cpu_reset), 1);
    send(8'hA5);
    chk("sync_done", 32'(done), 0);
    send(8'h00);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    chk("w0_we", 32'(rom_we), 1);
    chk("w0_addr", 32'(rom_addr), 0);
    chk("w0_data", 32'(rom_wdata), 32'h1234);
    send(8'hAB);
    chk("w0_pulse", 32'(rom_we), 0);
    send(8'hCD);
    chk("w1_we", 32'(rom_we), 1);
    chk("w1_addr", 32'(rom_addr), 1);
    chk("w1_data", 32'(rom_wdata), 32'hABCD);
    chk("w1_cpurst", 32'(cpu_reset), 1);
    chk("w1_done", 32'(done), 0);
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    send(8'h42);
`else
    idle(1);
`endif
    chk("fin_we", 32'(rom_we), 0);
    chk("fin_done", 32'(done), 1);
    chk("fin_cpurst", 32'(cpu_reset), 0);
    chk("fin_wcnt", wa_q.size(), 2);

    // inter-byte timeout, boundary cycle then abort
    wa_q = {};
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    idle(T - 1);
    chk("to_early_err", 32'(error), 0);
    idle(1);
    chk("to_err", 32'(error), 1);
    chk("to_cpurst", 32'(cpu_reset), 1);
    chk("to_done", 32'(done), 0);
    chk("to_wcnt", wa_q.size(), 0);
    send(8'hA5);
    chk("rec_err_clr", 32'(error), 0);
    send(8'h00);
    send(8'h00);
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk("rec_done", 32'(done), 1);
    chk("rec_err", 32'(error), 0);

    // length just over and exactly at the limit
    wa_q = {};
    send(8'hA5);
    send(8'h80);
    send(8'h01);
    chk("len8001_err", 32'(error), 1);
    idle(2);
    chk("len8001_wcnt", wa_q.size(), 0);
    send(8'hA5);
    send(8'h80);
    send(8'h00);
    chk("len8000_err", 32'(error), 0);
    chk("len8000_done", 32'(done), 0);
    do_reset();

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    wa_q = {};
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h07);
    chk("badck_we", 32'(rom_we), 1);
    chk("badck_data", 32'(rom_wdata), 32'h0007);
    send(8'h00);
    chk("badck_err", 32'(error), 1);
    chk("badck_cpurst", 32'(cpu_reset), 1);
    chk("badck_done", 32'(done), 0);
`endif

    // restart from DONE, then reset between data bytes
    send(8'hA5);
    send(8'h00);
    send(8'h00);
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk("dn_done", 32'(done), 1);
    send(8'h11);
    send(8'h22);
    chk("dn_ign_done", 32'(done), 1);
    wa_q = {};
    wd_q = {};
    send(8'hA5);
    chk("dn_sync_cpurst", 32'(cpu_reset), 1);
    chk("dn_sync_done", 32'(done), 0);
    send(8'h00);
    send(8'h01);
    send(8'hFF);
    send(8'hFF);
    chk("dn_w_addr", 32'(rom_addr), 0);
    chk("dn_w_data", 32'(rom_wdata), 32'hFFFF);
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    send(8'h01);
`else
    idle(1);
`endif
    chk("dn2_done", 32'(done), 1);
    wa_q = {};
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'hFF);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send(8'hFF);
    idle(2);
    chk("mid_rst_wcnt", wa_q.size(), 0);
    chk("mid_rst_cpurst", 32'(cpu_reset), 1);
    chk("mid_rst_done", 32'(done), 0);

    // vector table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      fr = {};
      for (int i = 0; i < tbl[v].n; i++) fr.push_back(tbl[v].b[i]);
      if (CHK_EN && tbl[v].c) fr.push_back(fr_xor());
      run_frame($sformatf("tbl%0d", v), 1'b0);
      chk($sformatf("tbl%0d_wexp", v), wa_q.size(), tbl[v].w);
      chk($sformatf("tbl%0d_dexp", v), 32'(done), 32'(tbl[v].d));
      chk($sformatf("tbl%0d_eexp", v), 32'(error), 32'(tbl[v].e));
    end

    // random back-to-back frames with gaps and garbage prefixes
    do_reset();
    for (int r = 0; r < 40; r++) begin
      fr = {};
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h3C;
        fr.push_back(g);
      end
      fr.push_back(SYNC);
      len = $urandom_range(0, 5);
      fr.push_back(8'(len >> 8));
      fr.push_back(8'(len));
      for (int k = 0; k < 2 * len; k++) fr.push_back(8'($urandom));
      if (CHK_EN) begin
        g = fr_xor();
        if ($urandom_range(0, 3) == 0) g ^= 8'($urandom_range(1, 255));
        fr.push_back(g);
      end
      run_frame($sformatf("rnd%0d", r), 1'b1);
    end

    chk("we_while_running", bad_we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Upstream stage of the Hack CPU: receives a program image as a byte stream from a UART receiver and writes it word by word into the instruction ROM.
- Holds the CPU in reset while loading and releases it once the image has been fully written.
- Framing: sync byte, 16-bit word count, big-endian 16-bit instruction words.

Parameters:
- ADDR_W, 15, instruction ROM address width; maximum image length is 2^ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle clock cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  reset, synchronous, active-high.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- rom_we  output  1  ROM write enable, one cycle per word.
- rom_addr  output  ADDR_W  ROM write address.
- rom_wdata  output  16  ROM write data.
- cpu_reset  output  1  drives the CPU reset input.
- done  output  1  image loaded; CPU running.
- error  output  1  last frame aborted.

Behaviour:
- There is no backpressure. Every rx_valid byte is consumed in the cycle it arrives.
- Reset values: state=IDLE, rom_we=0, rom_addr=0, rom_wdata=0, cpu_reset=1, done=0, error=0. Word counter and timeout counter are cleared.
- Reset mid-frame abandons the frame immediately. Words already written are left in ROM.
- State machine:
  - IDLE: non-sync bytes are ignored. SYNC_BYTE moves to LEN_HI and clears error.
  - LEN_HI: the byte becomes len[15:8]; move to LEN_LO.
  - LEN_LO: the byte becomes len[7:0].
    - len > 2^ADDR_W: go to ERROR.
    - len == 0: go to CHK if enabled, otherwise DONE.
    - Otherwise: go to DATA_HI with the address counter at 0.
  - DATA_HI: the byte is held as word[15:8]; move to DATA_LO.
  - DATA_LO: the byte completes the word.
    - Next cycle: rom_we=1 for exactly one cycle, with rom_addr = current address and rom_wdata = {hi, lo} (one-cycle registered latency).
    - The address then increments.
    - After the len-th word: go to CHK if enabled, otherwise DONE. Otherwise return to DATA_HI.
  - DONE: done=1, cpu_reset=0. Non-sync bytes are ignored. SYNC_BYTE restarts at LEN_HI and sets cpu_reset=1 and done=0 in the next cycle.
  - ERROR: error=1, cpu_reset=1, done=0. SYNC_BYTE restarts at LEN_HI and clears error.
- cpu_reset is 1 in every state except DONE. It deasserts in the cycle after the final write or the CHK pass, so the final rom_we always precedes the CPU leaving reset.
- Timeout:
  - The counter clears on every accepted byte.
  - In LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK it increments each cycle with no byte.
  - When it reaches TIMEOUT_CYCLES-1 the block goes to ERROR.
  - The counter is inactive in IDLE, DONE and ERROR.
- SYNC_BYTE inside a frame is treated as data, not as a restart.
- The address counter never wraps: the length check rejects images that would overflow it.
- rom_we is never asserted outside DATA_LO completion.

Optional Feature:
- Macro: HACK_ROM_LOADER_CHECKSUM_EN.
- When defined:
  - A running 8-bit XOR covers both length bytes and all data bytes.
  - After the last word (or after LEN_LO when len == 0), state CHK takes one byte. A match goes to DONE; a mismatch goes to ERROR.
  - Words already written stay written, and the CPU stays in reset.
- When undefined: the CHK state and the XOR register are absent, and the frame ends after the last data word.

Test Plan:
- Reset release, then bytes 00 12 A5 ignored up to the sync byte: no rom_we, cpu_reset=1, done=0 throughout.
- Frame A5 00 02 12 34 AB CD (plus checksum 00^02^12^34^AB^CD=0x42 when the feature is enabled):
  - Writes addr0=0x1234, then addr1=0xABCD, each rom_we one cycle wide, one cycle after the low byte.
  - done=1 and cpu_reset=0 one cycle after the final write (or after the checksum byte).
- Frame A5 00 01 then silence for TIMEOUT_CYCLES cycles: error=1, cpu_reset=1, no rom_we. A following A5 00 00 (checksum 00 if enabled) recovers to done=1 with error=0.
- Length 0x8001 with ADDR_W=15: ERROR directly after LEN_LO, with zero writes.
- Checksum enabled, frame A5 00 01 00 07 with checksum 0x00 (expected 0x06): one write addr0=0x0007, then error=1 and cpu_reset stays 1.
- During DONE, bytes 11 22 are ignored. A5 00 01 FF FF reasserts cpu_reset the cycle after the sync byte, then writes addr0=0xFFFF. reset asserted between the two data bytes returns to IDLE with no write.
